// File: rtl/parity_frame_pkg.sv
// Purpose : shared definitions for the XOR-parity serial frame transmitter and receiver.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Frame format, LSB-first: start(0), DATA_W data bits, parity bit, stop(1).
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    // Parity-mode selectors
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// Purpose : running XOR of a serial bit stream, with clear and enable.
// Latency : 1 clk from an enabled bit to its effect on o_acc.
// Backpressure: none; folds in one bit on every cycle i_en=1.
//
// Ports:
//   i_clk   clock, rising edge
//   i_reset synchronous active-high reset, clears the accumulator
//   i_clr   synchronous clear (takes priority over i_en)
//   i_en    fold i_bit into the accumulator this cycle
//   i_bit   serial bit
//   o_acc   current XOR of all bits folded in since the last clear
module parity_acc (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);

    logic r_acc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= 1'b0;
        end else if (i_clr) begin
            r_acc <= 1'b0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/parity_frame_rx.sv
// Purpose : deserializes one XOR-parity frame and presents the word on valid/ready.
// Latency : o_out_valid rises 1 clk after the edge that samples the stop bit.
// Backpressure: one-word holding register; a word finishing while it is still full is dropped and flagged by o_overrun.
//
// Optional feature: define PARITY_FRAME_RX_ERR_CNT_EN to add the saturating o_err_cnt output.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset (discards any partial frame)
//   i_rx_bit      serial line value, sampled only when i_bit_en=1
//   i_bit_en      one-cycle strobe from the line sampler
//   o_out_data    received word (holds its last value after acceptance)
//   o_out_valid   o_out_data/o_parity_err valid; held until accepted
//   i_out_ready   consumer accepts when o_out_valid & i_out_ready
//   o_parity_err  word was received with a parity mismatch
//   o_frame_err   one-cycle pulse: stop bit sampled as 0
//   o_overrun     one-cycle pulse: good frame dropped because the previous word was unaccepted
//   o_err_cnt     (optional) saturating count of parity/frame/overrun events
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_bit,
    input  logic              i_bit_en,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    ,
    output logic [7:0]        o_err_cnt
`endif
);

    localparam int   CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic P_MODE   = (ODD_PARITY != 0) ? ODD : EVEN;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_perr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;

    logic w_acc;
    logic w_accept;
    logic w_start;
    logic w_data_smp;
    logic w_stop_smp;
    logic w_good;
    logic w_load;
    logic w_ovr_evt;
    logic w_ferr_evt;

    assign w_accept   = r_out_valid & i_out_ready;
    assign w_start    = i_bit_en & (r_state == IDLE) & (i_rx_bit == FRAME_START);
    assign w_data_smp = i_bit_en & (r_state == DATA);
    assign w_stop_smp = i_bit_en & (r_state == STOP);
    assign w_good     = w_stop_smp & (i_rx_bit == FRAME_STOP);
    assign w_ferr_evt = w_stop_smp & (i_rx_bit != FRAME_STOP);
    // A slot frees up in the same cycle the consumer takes the old word.
    assign w_load     = w_good & (~r_out_valid | w_accept);
    assign w_ovr_evt  = w_good & r_out_valid & ~i_out_ready;

    parity_acc u_acc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_start),
        .i_en    (w_data_smp),
        .i_bit   (i_rx_bit),
        .o_acc   (w_acc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_evt;
            r_overrun   <= w_ovr_evt;

            if (w_load) begin
                r_out_data   <= r_shift;
                r_parity_err <= r_perr;
                r_out_valid  <= 1'b1;
            end else if (w_accept) begin
                r_out_valid  <= 1'b0;
                r_parity_err <= 1'b0;
            end

            if (i_bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (i_rx_bit == FRAME_START) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                        end
                    end
                    DATA: begin
                        r_shift[r_cnt] <= i_rx_bit;
                        if (r_cnt == LAST_BIT) begin
                            r_cnt   <= '0;
                            r_state <= PARITY;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        r_perr  <= w_acc ^ i_rx_bit ^ P_MODE;
                        r_state <= STOP;
                    end
                    // A 0 stop bit returns to IDLE without being taken as a start bit.
                    STOP: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_out_data   = r_out_data;
    assign o_out_valid  = r_out_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_err_evt;

    // Events are mutually exclusive within a cycle, so +1 is enough.
    assign w_err_evt = (w_load & r_perr) | w_ferr_evt | w_ovr_evt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

    logic       clk;
    logic       reset;
    logic       rx_bit;
    logic       bit_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_vec;
    int n_miss;

    // Output-event monitor (reads outputs only, on the falling edge)
    int         n_vld;
    int         n_ferr;
    int         n_ovr;
    logic [7:0] last_vld_data;
    logic       last_vld_perr;

    parity_frame_rx #(
        .DATA_W     (8),
        .ODD_PARITY (0)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rx_bit     (rx_bit),
        .i_bit_en     (bit_en),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_parity_err (parity_err),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun)
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        ,
        .o_err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_vld = 0;
        n_ferr = 0;
        n_ovr = 0;
        last_vld_data = 8'h00;
        last_vld_perr = 1'b0;
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_vld = n_vld + 1;
            last_vld_data = out_data;
            last_vld_perr = parity_err;
        end
        if (frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (overrun === 1'b1) n_ovr = n_ovr + 1;
    end

    // One bit_en strobe, followed by 'gap' idle cycles.
    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        rx_bit = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        rx_bit = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        send_bit(stp, gap);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_bit = 1'b0;
        bit_en = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL reset_data got=%h exp=00", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        n_vec++; if (overrun !== 1'b0) begin n_miss++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        bit_en = 1'b0;
        rx_bit = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame;
        int v0, f0;
        out_ready = 1'b1;
        v0 = n_vld; f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        n_vec++; if (n_vld - v0 != 1) begin n_miss++; $display("FAIL good_valid_cycles got=%0d exp=1", n_vld - v0); end
        n_vec++; if (last_vld_data !== 8'hA5) begin n_miss++; $display("FAIL good_data got=%h exp=a5", last_vld_data); end
        n_vec++; if (last_vld_perr !== 1'b0) begin n_miss++; $display("FAIL good_perr got=%b exp=0", last_vld_perr); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL good_valid_drop got=%b exp=0", out_valid); end
        n_vec++; if (out_data !== 8'hA5) begin n_miss++; $display("FAIL good_data_hold got=%h exp=a5", out_data); end
        n_vec++; if (n_ferr != f0) begin n_miss++; $display("FAIL good_no_ferr got=%0d exp=0", n_ferr - f0); end
    endtask

    task automatic test_parity_err;
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1);
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL perr_valid got=%b exp=1", out_valid); end
        n_vec++; if (out_data !== 8'hA5) begin n_miss++; $display("FAIL perr_data got=%h exp=a5", out_data); end
        n_vec++; if (parity_err !== 1'b1) begin n_miss++; $display("FAIL perr_flag got=%b exp=1", parity_err); end
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL perr_held got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL perr_accept_valid got=%b exp=0", out_valid); end
        n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL perr_accept_flag got=%b exp=0", parity_err); end
        n_vec++; if (out_data !== 8'hA5) begin n_miss++; $display("FAIL perr_accept_data got=%h exp=a5", out_data); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        out_ready = 1'b1;
        v0 = n_vld; f0 = n_ferr;
        send_frame(8'h3C, ^8'h3C, 1'b0, 1);
        n_vec++; if (n_ferr - f0 != 1) begin n_miss++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - f0); end
        n_vec++; if (n_vld != v0) begin n_miss++; $display("FAIL ferr_no_valid got=%0d exp=0", n_vld - v0); end
        v0 = n_vld; f0 = n_ferr;
        send_frame(8'h11, ^8'h11, 1'b1, 1);
        n_vec++; if (n_vld - v0 != 1) begin n_miss++; $display("FAIL ferr_next_valid got=%0d exp=1", n_vld - v0); end
        n_vec++; if (last_vld_data !== 8'h11) begin n_miss++; $display("FAIL ferr_next_data got=%h exp=11", last_vld_data); end
        n_vec++; if (last_vld_perr !== 1'b0) begin n_miss++; $display("FAIL ferr_next_perr got=%b exp=0", last_vld_perr); end
        n_vec++; if (n_ferr != f0) begin n_miss++; $display("FAIL ferr_next_clean got=%0d exp=0", n_ferr - f0); end
    endtask

    task automatic test_overrun;
        int o0;
        out_ready = 1'b0;
        o0 = n_ovr;
        send_frame(8'h12, ^8'h12, 1'b1, 1);
        send_frame(8'h34, ^8'h34, 1'b1, 1);
        n_vec++; if (n_ovr - o0 != 1) begin n_miss++; $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - o0); end
        n_vec++; if (out_data !== 8'h12) begin n_miss++; $display("FAIL ovr_data got=%h exp=12", out_data); end
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
        n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL ovr_perr got=%b exp=0", parity_err); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL ovr_accept got=%b exp=0", out_valid); end
        n_vec++; if (out_data !== 8'h12) begin n_miss++; $display("FAIL ovr_accept_data got=%h exp=12", out_data); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        out_ready = 1'b0;
        send_frame(8'h77, ^8'h77, 1'b1, 1);
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL mid_rst_data got=%h exp=00", out_data); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL mid_rst_perr got=%b exp=0", parity_err); end
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        v0 = n_vld;
        send_frame(8'h5A, ^8'h5A, 1'b1, 1);
        n_vec++; if (n_vld - v0 != 1) begin n_miss++; $display("FAIL mid_next_valid got=%0d exp=1", n_vld - v0); end
        n_vec++; if (last_vld_data !== 8'h5A) begin n_miss++; $display("FAIL mid_next_data got=%h exp=5a", last_vld_data); end
        n_vec++; if (last_vld_perr !== 1'b0) begin n_miss++; $display("FAIL mid_next_perr got=%b exp=0", last_vld_perr); end
    endtask

    task automatic test_back_to_back;
        int v0;
        out_ready = 1'b1;
        v0 = n_vld;
        send_frame(8'hC3, ^8'hC3, 1'b1, 0);
        send_frame(8'h81, ~(^8'h81), 1'b1, 0);
        repeat (2) @(negedge clk);
        n_vec++; if (n_vld - v0 != 2) begin n_miss++; $display("FAIL b2b_count got=%0d exp=2", n_vld - v0); end
        n_vec++; if (last_vld_data !== 8'h81) begin n_miss++; $display("FAIL b2b_data got=%h exp=81", last_vld_data); end
        n_vec++; if (last_vld_perr !== 1'b1) begin n_miss++; $display("FAIL b2b_perr got=%b exp=1", last_vld_perr); end
    endtask

`ifdef PARITY_FRAME_RX_ERR_CNT_EN
    task automatic test_err_cnt;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) send_frame(8'h00, 1'b1, 1'b1, 0);
        repeat (2) @(negedge clk);
        n_vec++; if (err_cnt !== 8'hFF) begin n_miss++; $display("FAIL errcnt_sat got=%h exp=ff", err_cnt); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (err_cnt !== 8'h00) begin n_miss++; $display("FAIL errcnt_reset got=%h exp=00", err_cnt); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        rx_bit = 1'b1;
        bit_en = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
`ifdef PARITY_FRAME_RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
- Receive-side counterpart of the team's XOR-parity serial frame transmitter.
- Deserializes one frame, LSB-first: start(0), DATA_W data bits, parity bit, stop(1).
- Recomputes parity with an XOR reduction and hands the word downstream on a valid/ready interface.
- Sits between the serial line sampler (supplies bit_en) and the datapath consumer.

Parameters:
- DATA_W, 8: data bits per frame (legal range 1..16).
- ODD_PARITY, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- rx_bit  in  1  serial line value; sampled only when bit_en=1.
- bit_en  in  1  one-cycle strobe: rx_bit holds a new bit this cycle.
- out_data  out  DATA_W  received word.
- out_valid  out  1  out_data/parity_err valid; held until accepted.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- parity_err  out  1  qualifies out_data: parity mismatch; held with out_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: frame completed while the previous word was unaccepted.

Behaviour:
- Reset values (cycle after reset=1): state=IDLE; out_data=0; out_valid=0; parity_err=0; frame_err=0; overrun=0; bit counter=0; parity accumulator=0.
- Reset wins over all other inputs, including mid-frame. A partial frame is discarded.
- All transitions advance only on cycles with bit_en=1. Cycles with bit_en=0 hold state.
- FSM:
  - IDLE: rx_bit=0 -> DATA (cnt=0, acc=0). rx_bit=1 -> stay.
  - DATA: shift rx_bit into shift_reg at position cnt (LSB first); acc ^= rx_bit; cnt++. After bit DATA_W-1 -> PARITY.
  - PARITY: perr = acc ^ rx_bit ^ ODD_PARITY -> STOP.
  - STOP, rx_bit=1: frame good -> IDLE, then the delivery rule below.
  - STOP, rx_bit=0: frame_err=1 for one cycle; word dropped; no output change -> IDLE.
    - The 0 is not treated as a new start bit; the next start bit needs its own bit_en.
- Delivery on a good frame:
  - If out_valid=0, or out_valid&out_ready in the same cycle: load out_data=shift_reg and parity_err=perr; out_valid=1.
  - Otherwise: overrun=1 for one cycle; new word dropped; old word and flags retained.
- Latency: out_valid rises the cycle after the clk edge that samples the stop bit (1 clk).
- Handshake:
  - out_valid&out_ready with no new word: out_valid->0, parity_err->0; out_data holds its last value.
  - out_valid never drops without acceptance.
- A parity error does not drop the word; it is delivered flagged.
- Counter width: clog2(DATA_W) bits minimum. cnt wraps to 0 on leaving DATA.

Optional Feature:
- Macro: PARITY_FRAME_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 on each delivered parity_err word, frame_err pulse, or overrun pulse.
  - Saturates at 8'hFF.
  - Two events cannot occur in one cycle.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package parity_frame_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP} (2-bit);
  - constants FRAME_START=1'b0 and FRAME_STOP=1'b1;
  - parity-mode constants EVEN=0 and ODD=1.
- Shared with the transmitter.
- One sub-module: parity_acc. It is the XOR accumulator with clear/enable, and the transmitter reuses it.

Test Plan:
- DATA_W=8, even parity; send 0xA5 as bits 0,1,0,1,0,0,1,0,1,0,1 (parity 0, stop 1), one bit_en per 3 clks, out_ready=1 -> out_data=0xA5, parity_err=0, valid for exactly 1 cycle.
- Same frame with parity bit=1 -> out_data=0xA5, parity_err=1, out_valid=1.
- 0x3C frame with stop bit=0 -> frame_err pulses for 1 cycle, out_valid stays 0; next good frame 0x11 is received normally.
- out_ready=0; send 0x12, then 0x34 -> out_data stays 0x12, overrun pulses once at the end of 0x34. Raise out_ready -> 0x12 accepted, out_valid=0.
- Assert reset after 4 data bits of 0xFF; release; send 0x5A -> all outputs 0 during reset, then out_data=0x5A with no error.
- With PARITY_FRAME_RX_ERR_CNT_EN: 300 frames with bad parity -> err_cnt=8'hFF (saturated); reset -> 0.
